pc_stack_reg: RTL and testbench

//   Parametrised program counter with an integrated hardware return-address stack.
//   - Supports increment, absolute load (bus or MDR), signed relative branch, call and return.
//   - Replaces the fixed 16-bit PC in the fetch path.
//   - Lets call/return complete in one cycle without memory traffic.

---
 rtl/pc_stack_reg.sv | 122 ++++++++++++
 tb/tb_pc_stack_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_reg.sv
// Program counter with an integrated circular return-address stack.
// Supports increment, absolute load, relative branch, call, return and tail call.
module pc_stack_reg #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [WIDTH-1:0]             val,
    input  logic [WIDTH-1:0]             bus_in,
    input  logic                         bus_we,
    input  logic [WIDTH-1:0]             mdr_in,
    input  logic                         mdr_we,
    input  logic [WIDTH-1:0]             rel_in,
    input  logic                         rel_we,
    input  logic                         inc,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             tos,
    output logic [$clog2(DEPTH+1)-1:0]   sp_count,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] val_q, val_d;
    logic [PW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_c;
    logic [WIDTH-1:0] ret_addr_c;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             full_c;
    logic             empty_c;

    assign full_c     = (cnt_q == CW'(DEPTH));
    assign empty_c    = (cnt_q == '0);
    assign ret_addr_c = val_q + WIDTH'(STEP);

    // Top entry sits just below the write pointer; empty stack reads as zero.
    assign tos = empty_c ? '0 : mem_q[wp_q - PW'(1)];

    // Next-state: one action per cycle, highest priority first.
    always_comb begin
        val_d  = val_q;
        wp_d   = wp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q & ~clr_err;
        unf_d  = unf_q & ~clr_err;
        push_c = 1'b0;

        if (call && ret) begin
            val_d = mdr_in;
        end else if (ret) begin
            if (!empty_c) begin
                val_d = tos;
                wp_d  = wp_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end else begin
                val_d = ret_addr_c;
                unf_d = 1'b1;
            end
        end else if (call) begin
            push_c = 1'b1;
            wp_d   = wp_q + PW'(1);
            val_d  = mdr_in;
            if (full_c) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (mdr_we) begin
            val_d = mdr_in;
        end else if (bus_we) begin
            val_d = bus_in;
        end else if (rel_we) begin
            val_d = val_q + rel_in;
        end else if (inc) begin
            val_d = ret_addr_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= RESET_VEC;
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            val_q <= val_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage has no reset; a full push overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            mem_q[wp_q] <= ret_addr_c;
        end
    end

    assign val         = val_q;
    assign sp_count    = cnt_q;
    assign stack_full  = full_c;
    assign stack_empty = empty_c;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_pc_stack_reg.sv
// Directed self-checking bench for pc_stack_reg (WIDTH=16, DEPTH=8, STEP=1).
module tb_pc_stack_reg;

    logic        clk;
    logic        rst;
    logic [15:0] val;
    logic [15:0] bus_in;
    logic        bus_we;
    logic [15:0] mdr_in;
    logic        mdr_we;
    logic [15:0] rel_in;
    logic        rel_we;
    logic        inc;
    logic        call;
    logic        ret;
    logic        clr_err;
    logic [15:0] tos;
    logic [3:0]  sp_count;
    logic        stack_full;
    logic        stack_empty;
    logic        overflow;
    logic        underflow;

    int tests = 0;
    int fails = 0;

    pc_stack_reg #(
        .WIDTH(16), .DEPTH(8), .STEP(1), .RESET_VEC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .val(val),
        .bus_in(bus_in), .bus_we(bus_we),
        .mdr_in(mdr_in), .mdr_we(mdr_we),
        .rel_in(rel_in), .rel_we(rel_we),
        .inc(inc), .call(call), .ret(ret), .clr_err(clr_err),
        .tos(tos), .sp_count(sp_count),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus_we = 1'b0; mdr_we = 1'b0; rel_we = 1'b0; inc = 1'b0;
        call = 1'b0; ret = 1'b0; clr_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        clear_in();
        bus_in = v; bus_we = 1'b1;
        tick();
        clear_in();
    endtask

    initial begin
        clear_in();
        bus_in = '0; mdr_in = '0; rel_in = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Asynchronous reset in mid-cycle with inc held high
        inc = 1'b1;
        #3 rst = 1'b1;
        #1;
        check("rst_val",      32'(val), 32'h0);
        check("rst_sp",       32'(sp_count), 32'd0);
        check("rst_tos",      32'(tos), 32'h0);
        check("rst_empty",    32'(stack_empty), 32'd1);
        check("rst_ovf",      32'(overflow), 32'd0);
        check("rst_unf",      32'(underflow), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_hold_val", 32'(val), 32'h0);
        tick();
        check("rst_inc_val",  32'(val), 32'h1);
        clear_in();

        // Single call / ret round trip
        load(16'h00FF);
        mdr_in = 16'h1000; call = 1'b1;
        tick(); clear_in();
        check("call_val", 32'(val), 32'h1000);
        check("call_tos", 32'(tos), 32'h0100);
        check("call_sp",  32'(sp_count), 32'd1);
        ret = 1'b1;
        tick(); clear_in();
        check("ret_val",   32'(val), 32'h0100);
        check("ret_empty", 32'(stack_empty), 32'd1);
        check("ret_tos",   32'(tos), 32'h0);

        // Nine calls into an eight-deep stack
        for (int i = 1; i <= 9; i++) begin
            load(16'(i * 16));
            mdr_in = 16'h5000; call = 1'b1;
            tick(); clear_in();
        end
        check("ovf_full", 32'(stack_full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_sp",   32'(sp_count), 32'd8);
        check("ovf_val",  32'(val), 32'h5000);
        check("ovf_tos",  32'(tos), 32'h0091);
        for (int k = 9; k >= 2; k--) begin
            ret = 1'b1;
            tick(); clear_in();
            check("lifo_val", 32'(val), 32'(k * 16 + 1));
        end
        check("lifo_empty", 32'(stack_empty), 32'd1);
        check("lifo_sp",    32'(sp_count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_err = 1'b1;
        tick(); clear_in();
        check("ovf_clr", 32'(overflow), 32'd0);

        // Underflow and clear-versus-set precedence
        load(16'h0040);
        ret = 1'b1;
        tick(); clear_in();
        check("unf_val",  32'(val), 32'h0041);
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_sp",   32'(sp_count), 32'd0);
        clr_err = 1'b1;
        tick(); clear_in();
        check("unf_clr", 32'(underflow), 32'd0);
        check("unf_clr_val", 32'(val), 32'h0041);
        clr_err = 1'b1; ret = 1'b1;
        tick(); clear_in();
        check("unf_set_wins", 32'(underflow), 32'd1);
        check("unf_set_val",  32'(val), 32'h0042);
        clr_err = 1'b1;
        tick(); clear_in();

        // Modular arithmetic
        load(16'hFFFF);
        inc = 1'b1;
        tick(); clear_in();
        check("wrap_inc", 32'(val), 32'h0000);
        load(16'h0010);
        rel_in = 16'hFFF0; rel_we = 1'b1;
        tick(); clear_in();
        check("rel_neg", 32'(val), 32'h0000);
        load(16'h0100);
        rel_in = 16'h0023; rel_we = 1'b1;
        tick(); clear_in();
        check("rel_pos", 32'(val), 32'h0123);

        // Priority: tail call ignores bus load and leaves the stack alone
        load(16'h0300);
        mdr_in = 16'h1234; call = 1'b1;
        tick(); clear_in();
        check("pri_setup_tos", 32'(tos), 32'h0301);
        mdr_in = 16'h2222; bus_in = 16'h7777;
        call = 1'b1; ret = 1'b1; bus_we = 1'b1;
        tick(); clear_in();
        check("tail_val", 32'(val), 32'h2222);
        check("tail_sp",  32'(sp_count), 32'd1);
        check("tail_tos", 32'(tos), 32'h0301);
        check("tail_ovf", 32'(overflow), 32'd0);
        check("tail_unf", 32'(underflow), 32'd0);
        mdr_in = 16'h3333; bus_in = 16'h4444;
        bus_we = 1'b1; mdr_we = 1'b1; inc = 1'b1;
        tick(); clear_in();
        check("mdr_over_bus", 32'(val), 32'h3333);
        bus_we = 1'b1; rel_we = 1'b1; inc = 1'b1; rel_in = 16'h0100;
        tick(); clear_in();
        check("bus_over_rel", 32'(val), 32'h4444);
        rel_we = 1'b1; inc = 1'b1; rel_in = 16'h0010;
        tick(); clear_in();
        check("rel_over_inc", 32'(val), 32'h4454);
        ret = 1'b1; mdr_we = 1'b1; mdr_in = 16'h9999;
        tick(); clear_in();
        check("ret_over_mdr", 32'(val), 32'h0301);

        // Tail call on an empty stack leaves flags clear
        call = 1'b1; ret = 1'b1; mdr_in = 16'h0ABC;
        tick(); clear_in();
        check("tail_empty_val", 32'(val), 32'h0ABC);
        check("tail_empty_unf", 32'(underflow), 32'd0);
        check("tail_empty_sp",  32'(sp_count), 32'd0);

        // Reset during a call
        mdr_in = 16'h5555; call = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_val", 32'(val), 32'h0);
        check("rst_mid_sp",  32'(sp_count), 32'd0);
        clear_in();
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mid_empty", 32'(stack_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
